// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - shared types and defaults for the ALU controller
// Purpose: opcode and FSM state enums, width defaults, opcode legality helper.
// Ports: none (package).
package alu_ctrl_pkg;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_REG_COUNT = 4;

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_NAND = 3'b010,
        OP_NOR  = 3'b011,
        OP_ADD  = 3'b100,
        OP_SUB  = 3'b101
    } aluOp_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_READ = 2'b01,
        ST_EXEC = 2'b10,
        ST_WB   = 2'b11
    } ctrlState_e;

    // Codes 110/111 are reserved and rejected with an error pulse.
    function automatic logic isLegalOp(input logic [2:0] op);
        return op <= 3'(OP_SUB);
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// rtl/alu_regfile.sv - general register file for the ALU controller
// Purpose: REG_COUNT x DATA_W registers.
// Ports: clk, rst_n (async clear); rdAddrA/rdDataA, rdAddrB/rdDataB operand
//        read ports (combinational); dbgAddr/dbgData debug read port
//        (combinational); wrEn/wrAddr/wrData synchronous write port.
module alu_regfile
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int REG_COUNT = DEF_REG_COUNT
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [$clog2(REG_COUNT)-1:0] rdAddrA,
    output logic [DATA_W-1:0]            rdDataA,
    input  logic [$clog2(REG_COUNT)-1:0] rdAddrB,
    output logic [DATA_W-1:0]            rdDataB,
    input  logic [$clog2(REG_COUNT)-1:0] dbgAddr,
    output logic [DATA_W-1:0]            dbgData,
    input  logic                         wrEn,
    input  logic [$clog2(REG_COUNT)-1:0] wrAddr,
    input  logic [DATA_W-1:0]            wrData
);

    logic [DATA_W-1:0] regs [REG_COUNT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else if (wrEn) begin
            regs[wrAddr] <= wrData;
        end
    end

    assign rdDataA = regs[rdAddrA];
    assign rdDataB = regs[rdAddrB];
    assign dbgData = regs[dbgAddr];

endmodule

// File: rtl/alu_controller.sv
// rtl/alu_controller.sv - sequencer driving an external combinational ALU
// Purpose: accepts one instruction per 3 cycles, reads operands, drives the
//          external ALU, writes the result back and updates Z/N flags.
// Ports: clk, rst_n; instr_valid/instr_ready handshake with instr_op,
//        instr_dst, instr_srca, instr_srcb, instr_imm_en, instr_imm;
//        alu_opcode/alu_a/alu_b to the ALU, alu_result from it;
//        done/error completion pulses; flag_z/flag_n; dbg_addr/dbg_data.
module alu_controller
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int REG_COUNT = DEF_REG_COUNT
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         instr_valid,
    output logic                         instr_ready,
    input  logic [2:0]                   instr_op,
    input  logic [$clog2(REG_COUNT)-1:0] instr_dst,
    input  logic [$clog2(REG_COUNT)-1:0] instr_srca,
    input  logic [$clog2(REG_COUNT)-1:0] instr_srcb,
    input  logic                         instr_imm_en,
    input  logic [DATA_W-1:0]            instr_imm,
    output logic [2:0]                   alu_opcode,
    output logic [DATA_W-1:0]            alu_a,
    output logic [DATA_W-1:0]            alu_b,
    input  logic [DATA_W-1:0]            alu_result,
    output logic                         done,
    output logic                         error,
    output logic                         flag_z,
    output logic                         flag_n,
    input  logic [$clog2(REG_COUNT)-1:0] dbg_addr,
    output logic [DATA_W-1:0]            dbg_data
);

    localparam int AW = $clog2(REG_COUNT);

    ctrlState_e stateQ, stateD;
    logic       acceptEn, readEn, execEn;

    logic [2:0]        opQ;
    logic [AW-1:0]     dstQ, srcaQ, srcbQ;
    logic              immEnQ;
    logic [DATA_W-1:0] immQ;
    logic [DATA_W-1:0] rdDataA, rdDataB;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ <= ST_IDLE;
        end else begin
            stateQ <= stateD;
        end
    end

    always_comb begin
        stateD      = stateQ;
        instr_ready = 1'b0;
        acceptEn    = 1'b0;
        readEn      = 1'b0;
        execEn      = 1'b0;
        case (stateQ)
            ST_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    acceptEn = 1'b1;
                    stateD   = ST_READ;
                end
            end
            ST_READ: begin
                readEn = 1'b1;
                stateD = isLegalOp(opQ) ? ST_EXEC : ST_IDLE;
            end
            ST_EXEC: begin
                execEn = 1'b1;
                stateD = ST_IDLE;
            end
            // Write-back completes in EXEC; WB is never entered.
            default: stateD = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opQ        <= '0;
            dstQ       <= '0;
            srcaQ      <= '0;
            srcbQ      <= '0;
            immEnQ     <= 1'b0;
            immQ       <= '0;
            alu_opcode <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            done       <= 1'b0;
            error      <= 1'b0;
            flag_z     <= 1'b0;
            flag_n     <= 1'b0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            if (acceptEn) begin
                opQ    <= instr_op;
                dstQ   <= instr_dst;
                srcaQ  <= instr_srca;
                srcbQ  <= instr_srcb;
                immEnQ <= instr_imm_en;
                immQ   <= instr_imm;
            end
            // Operands are captured before any write-back, so dst may alias a source.
            if (readEn) begin
                alu_opcode <= opQ;
                alu_a      <= rdDataA;
                alu_b      <= immEnQ ? immQ : rdDataB;
                error      <= !isLegalOp(opQ);
            end
            if (execEn) begin
                flag_z <= (alu_result == '0);
                flag_n <= alu_result[DATA_W-1];
                done   <= 1'b1;
            end
        end
    end

    alu_regfile #(
        .DATA_W   (DATA_W),
        .REG_COUNT(REG_COUNT)
    ) u_regfile (
        .clk    (clk),
        .rst_n  (rst_n),
        .rdAddrA(srcaQ),
        .rdDataA(rdDataA),
        .rdAddrB(srcbQ),
        .rdDataB(rdDataB),
        .dbgAddr(dbg_addr),
        .dbgData(dbg_data),
        .wrEn   (execEn),
        .wrAddr (dstQ),
        .wrData (alu_result)
    );

endmodule
